// File: rtl/acq_flow_mgr.sv
// Acquisition flow manager: FIFO block-ready handshake with hysteresis, host
// service timeout, sticky error flags, fill/service statistics and heartbeat.
module acq_flow_mgr #(
  parameter int COUNT_W         = 10,
  parameter int HIGH_WATER_MARK = 512,
  parameter int LOW_WATER_MARK  = 511,
  parameter int TIMEOUT_CYC     = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acq_clr,
  input  logic               stats_clr,
  input  logic [COUNT_W-1:0] fifo_wr_data_count,
  input  logic               fifo_of,
  output logic               acq_dv,
  output logic               of_latched,
  output logic               late_latched,
  output logic [7:0]         late_cnt,
  output logic [15:0]        block_cnt,
  output logic [COUNT_W-1:0] peak_fill,
  output logic               sec_tick,
  output logic               led_alive
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HB_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [COUNT_W-1:0] HWM      = COUNT_W'(HIGH_WATER_MARK);
  localparam logic [COUNT_W-1:0] LWM      = COUNT_W'(LOW_WATER_MARK);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [HB_W-1:0]    HB_LAST  = HB_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    LATE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [TMR_W-1:0]   timer;
  logic [HB_W-1:0]    hb_cnt;
  logic               above_hwm;
  logic               below_lwm;
  logic               timer_done;
  logic               serviced;
  logic               late_evt;
  logic               hb_wrap;

  assign above_hwm  = fifo_wr_data_count > HWM;
  assign below_lwm  = fifo_wr_data_count < LWM;
  assign timer_done = timer == TMR_LAST;
  assign hb_wrap    = hb_cnt == HB_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Release is tested before timeout so a coincident release counts as a
  // normal service rather than a late event.
  always_comb begin
    next_state = state;
    if (acq_clr) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (above_hwm) next_state = PEND;
        PEND: begin
          if (below_lwm) begin
            next_state = IDLE;
          end else if (timer_done) begin
            next_state = LATE;
          end
        end
        LATE: if (below_lwm) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    acq_dv   = state != IDLE;
    serviced = !acq_clr && (state != IDLE) && below_lwm;
    late_evt = !acq_clr && (state == PEND) && !below_lwm && timer_done;
  end

  // Timer counts only while staying in PEND, freezes in LATE, else zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state == PEND && next_state == PEND) begin
      timer <= timer + TMR_W'(1);
    end else if (next_state != LATE) begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      of_latched   <= 1'b0;
      late_latched <= 1'b0;
    end else begin
      if (fifo_of) begin
        of_latched <= 1'b1;
      end else if (acq_clr) begin
        of_latched <= 1'b0;
      end
      if (late_evt) begin
        late_latched <= 1'b1;
      end else if (acq_clr) begin
        late_latched <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_cnt <= '0;
      late_cnt  <= '0;
      peak_fill <= '0;
    end else if (stats_clr) begin
      block_cnt <= {15'd0, serviced};
      late_cnt  <= {7'd0, late_evt};
      peak_fill <= fifo_wr_data_count;
    end else begin
      if (serviced) begin
        block_cnt <= block_cnt + 16'd1;
      end
      if (late_evt && late_cnt != 8'hFF) begin
        late_cnt <= late_cnt + 8'd1;
      end
      if (fifo_wr_data_count > peak_fill) begin
        peak_fill <= fifo_wr_data_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt    <= '0;
      sec_tick  <= 1'b0;
      led_alive <= 1'b0;
    end else begin
      hb_cnt    <= hb_wrap ? '0 : hb_cnt + HB_W'(1);
      sec_tick  <= hb_wrap;
      led_alive <= led_alive ^ hb_wrap;
    end
  end

endmodule

// File: tb/tb_acq_flow_mgr.sv
// Self-checking bench for acq_flow_mgr: directed scenarios plus randomized
// segments, compared each cycle against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_acq_flow_mgr;

  localparam int CW  = 10;
  localparam int HWM = 512;
  localparam int LWM = 511;
  localparam int TO  = 100;
  localparam int TD  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          acq_clr = 1'b0;
  logic          stats_clr = 1'b0;
  logic [CW-1:0] fifo_wr_data_count = '0;
  logic          fifo_of = 1'b0;
  logic          acq_dv;
  logic          of_latched;
  logic          late_latched;
  logic [7:0]    late_cnt;
  logic [15:0]   block_cnt;
  logic [CW-1:0] peak_fill;
  logic          sec_tick;
  logic          led_alive;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: "ready" since edge t_start; late once TO edges pass unserviced.
  bit m_ready, m_late_phase, m_of, m_late_flag;
  int m_t, m_start, m_blocks, m_lates, m_peak;

  acq_flow_mgr #(
    .COUNT_W(CW),
    .HIGH_WATER_MARK(HWM),
    .LOW_WATER_MARK(LWM),
    .TIMEOUT_CYC(TO),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .acq_clr(acq_clr),
    .stats_clr(stats_clr),
    .fifo_wr_data_count(fifo_wr_data_count),
    .fifo_of(fifo_of),
    .acq_dv(acq_dv),
    .of_latched(of_latched),
    .late_latched(late_latched),
    .late_cnt(late_cnt),
    .block_cnt(block_cnt),
    .peak_fill(peak_fill),
    .sec_tick(sec_tick),
    .led_alive(led_alive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int cnt, input bit f_of, input bit aclr, input bit sclr, input bit r);
    bit svc = 0;
    bit lev = 0;
    if (r) begin
      m_ready = 0; m_late_phase = 0; m_of = 0; m_late_flag = 0;
      m_t = 0; m_start = 0; m_blocks = 0; m_lates = 0; m_peak = 0;
      return;
    end
    m_t++;
    if (aclr) begin
      m_ready = 0;
      m_late_phase = 0;
    end else if (!m_ready) begin
      if (cnt > HWM) begin
        m_ready = 1; m_late_phase = 0; m_start = m_t;
      end
    end else if (cnt < LWM) begin
      svc = 1; m_ready = 0; m_late_phase = 0;
    end else if (!m_late_phase && (m_t - m_start) == TO) begin
      lev = 1; m_late_phase = 1;
    end
    if (f_of) m_of = 1;
    else if (aclr) m_of = 0;
    if (lev) m_late_flag = 1;
    else if (aclr) m_late_flag = 0;
    if (sclr) begin
      m_blocks = svc;
      m_lates  = lev;
      m_peak   = cnt;
    end else begin
      m_blocks = (m_blocks + svc) % 65536;
      m_lates  = (m_lates + lev > 255) ? 255 : m_lates + lev;
      m_peak   = (cnt > m_peak) ? cnt : m_peak;
    end
  endtask

  task automatic compare_all();
    check("acq_dv", acq_dv, m_ready);
    check("of_latched", of_latched, m_of);
    check("late_latched", late_latched, m_late_flag);
    check("late_cnt", late_cnt, m_lates);
    check("block_cnt", block_cnt, m_blocks);
    check("peak_fill", peak_fill, m_peak);
    check("sec_tick", sec_tick, (m_t > 0 && m_t % TD == 0));
    check("led_alive", led_alive, (m_t / TD) % 2);
  endtask

  task automatic cyc(input int cnt, input bit f_of = 0, input bit aclr = 0,
                     input bit sclr = 0, input bit r = 0);
    fifo_wr_data_count = CW'(cnt);
    fifo_of   = f_of;
    acq_clr   = aclr;
    stats_clr = sclr;
    rst       = r;
    @(posedge clk);
    model_step(cnt, f_of, aclr, sclr, r);
    #1;
    compare_all();
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 1);
    check("rst_dv", acq_dv, 0);
    check("rst_block", block_cnt, 0);
    check("rst_led", led_alive, 0);

    // Ramp up past high water, hold, drop below low water
    for (int c = 0; c <= 512; c += 64) cyc(c);
    check("ramp_hold_512", acq_dv, 0);
    cyc(513);
    check("ramp_rise", acq_dv, 1);
    repeat (20) cyc(513);
    cyc(512);
    cyc(511);
    check("ramp_hyst", acq_dv, 1);
    cyc(510);
    check("ramp_fall", acq_dv, 0);
    check("ramp_block", block_cnt, 1);
    check("ramp_late", late_cnt, 0);

    // Service timeout
    cyc(0, 0, 1, 1);
    repeat (100) cyc(600);
    check("to_not_yet", late_latched, 0);
    cyc(600);
    check("to_latched", late_latched, 1);
    check("to_late_cnt", late_cnt, 1);
    check("to_dv_held", acq_dv, 1);
    repeat (48) cyc(600);
    cyc(400);
    check("to_release_dv", acq_dv, 0);
    check("to_release_block", block_cnt, 1);

    // Release on the final timer cycle wins over timeout
    cyc(0, 0, 1, 1);
    repeat (100) cyc(600);
    cyc(400);
    check("edge_dv", acq_dv, 0);
    check("edge_block", block_cnt, 1);
    check("edge_late_flag", late_latched, 0);
    check("edge_late_cnt", late_cnt, 0);

    // Overflow sticky flag vs acq_clr
    cyc(0, 1);
    check("of_set", of_latched, 1);
    cyc(0, 0, 1);
    check("of_clr", of_latched, 0);
    cyc(0, 1, 1);
    check("of_set_wins", of_latched, 1);
    check("of_block", block_cnt, 1);

    // Peak fill and stats clear
    cyc(0, 0, 1, 1);
    cyc(700);
    cyc(510);
    check("peak_700", peak_fill, 700);
    cyc(300, 0, 0, 1);
    check("peak_300", peak_fill, 300);
    check("sclr_block", block_cnt, 0);
    check("sclr_late", late_cnt, 0);

    // Late counter saturation
    for (int i = 0; i < 300; i++) begin
      repeat (101) cyc(600);
      cyc(400);
    end
    check("late_sat", late_cnt, 255);
    check("sat_block", block_cnt, 300);

    // Heartbeat and reset in the middle of PEND
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 30; i++) begin
      cyc(0);
      check("hb_tick", sec_tick, (i % TD == 0));
      check("hb_led", led_alive, (i / TD) % 2);
    end
    repeat (20) cyc(600);
    cyc(600, 1, 1, 1, 1);
    check("mid_rst_dv", acq_dv, 0);
    check("mid_rst_of", of_latched, 0);
    check("mid_rst_peak", peak_fill, 0);
    check("mid_rst_tick", sec_tick, 0);
    check("mid_rst_led", led_alive, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0);
      check("hb_restart", sec_tick, (i == TD));
    end

    // Randomized segments around the thresholds
    for (int seg = 0; seg < 60; seg++) begin
      int band = $urandom_range(0, 4);
      int len  = $urandom_range(1, 130);
      for (int k = 0; k < len; k++) begin
        int cnt;
        case (band)
          0: cnt = $urandom_range(0, 400);
          1: cnt = $urandom_range(508, 515);
          2: cnt = $urandom_range(511, 512);
          3: cnt = $urandom_range(513, 1023);
          default: cnt = $urandom_range(0, 1023);
        endcase
        cyc(cnt, $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 999) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_flow_mgr.md
ACQ_FLOW_MGR -- requirements
Module: acq_flow_mgr

Interface
REQ-001 Parameter COUNT_W, default 10: width of the FIFO write data count.
REQ-002 Parameter HIGH_WATER_MARK, default 512: the block-ready trigger asserts when the count exceeds this value.
REQ-003 Parameter LOW_WATER_MARK, default 511: the trigger releases when the count falls below this value; LOW_WATER_MARK <= HIGH_WATER_MARK.
REQ-004 Parameter TIMEOUT_CYC, default 500000 (5 ms at 100 MHz): maximum allowed host service latency, in clk cycles.
REQ-005 Parameter TICK_DIV, default 50000000: heartbeat period, in clk cycles.
REQ-006 Port `clk`, input, 1 bit: 100 MHz buffered system clock; the block has one clock.
REQ-007 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-008 Port `acq_clr`, input, 1 bit: synchronous clear of the acquisition state; this is the CAM FIFO reset.
REQ-009 Port `stats_clr`, input, 1 bit: single-cycle pulse that clears the statistics.
REQ-010 Port `fifo_wr_data_count`, input, COUNT_W bits: FIFO fill count, synchronous to clk.
REQ-011 Port `fifo_of`, input, 1 bit: FIFO overflow strobe.
REQ-012 Port `acq_dv`, output, 1 bit: block-ready flag to the host.
REQ-013 Port `of_latched`, output, 1 bit: sticky overflow flag.
REQ-014 Port `late_latched`, output, 1 bit: sticky service-timeout flag.
REQ-015 Port `late_cnt`, output, 8 bits: count of late-service events.
REQ-016 Port `block_cnt`, output, 16 bits: count of blocks that were serviced.
REQ-017 Port `peak_fill`, output, COUNT_W bits: maximum fill count seen since the last clear.
REQ-018 Port `sec_tick`, output, 1 bit: one-cycle heartbeat strobe.
REQ-019 Port `led_alive`, output, 1 bit: heartbeat LED.

Function
REQ-020 The flow FSM SHALL have three states: IDLE (acq_dv=0), PEND (acq_dv=1, service timer running) and LATE (acq_dv=1, timer stopped).
REQ-021 IDLE SHALL go to PEND when fifo_wr_data_count > HIGH_WATER_MARK; acq_dv is registered and asserts one cycle after the qualifying count is sampled.
REQ-022 On entry to PEND, the service timer SHALL load 0 and increment by one per cycle while in PEND.
REQ-023 PEND SHALL go to IDLE when count < LOW_WATER_MARK, and block_cnt SHALL increment by 1 (16-bit wrap, 0xFFFF -> 0x0000).
REQ-024 PEND SHALL go to LATE when the timer reaches TIMEOUT_CYC-1 and count >= LOW_WATER_MARK.
- On that transition: late_latched <= 1; late_cnt increments, saturating at 255.
REQ-025 If the release condition and the timeout coincide in the same cycle, the release SHALL win: go to IDLE, increment block_cnt, no late event.
REQ-026 LATE SHALL go to IDLE when count < LOW_WATER_MARK, and block_cnt SHALL increment.
REQ-027 While count lies between LOW_WATER_MARK and HIGH_WATER_MARK inclusive, the FSM SHALL hold its state (hysteresis).
REQ-028 of_latched SHALL set on any cycle in which fifo_of=1 and SHALL stay set until rst or acq_clr.
- If fifo_of and acq_clr occur in the same cycle, the set SHALL win.
REQ-029 acq_clr SHALL force: FSM to IDLE, timer 0, acq_dv 0, late_latched 0, of_latched 0 (unless fifo_of is set that cycle).
- block_cnt, late_cnt and peak_fill SHALL be unaffected by acq_clr.
- The heartbeat SHALL be unaffected by acq_clr.
REQ-030 peak_fill SHALL update each cycle to max(peak_fill, fifo_wr_data_count), using unsigned COUNT_W-bit comparison.
REQ-031 stats_clr SHALL zero block_cnt and late_cnt, and SHALL load fifo_wr_data_count into peak_fill.
- If a block_cnt or late_cnt increment coincides with stats_clr, the counter SHALL load 1 instead of 0.
REQ-032 The heartbeat counter SHALL count 0..TICK_DIV-1 and wrap.
- sec_tick SHALL be 1 for exactly the one cycle after the counter reaches TICK_DIV-1.
- led_alive SHALL toggle in the cycle sec_tick=1.
REQ-033 Every comparison against a parameter SHALL be done at COUNT_W width (HWM/LWM) or at timer width (TIMEOUT_CYC), so no truncation occurs.

Reset
REQ-034 rst SHALL set the following to 0: FSM (IDLE), timer, heartbeat counter, acq_dv, of_latched, late_latched, late_cnt, block_cnt, peak_fill, sec_tick and led_alive.
REQ-035 rst SHALL take precedence over acq_clr, stats_clr and fifo_of, including in the middle of PEND or LATE.

Verification
REQ-036 Count ramp 0 -> 513 -> hold -> 510, with TIMEOUT_CYC=100.
- Expect acq_dv to rise one cycle after 513 is sampled and to fall one cycle after 510 is sampled.
- Expect block_cnt=1 and late_cnt=0.
REQ-037 Count held at 600 for 150 cycles, with TIMEOUT_CYC=100.
- Expect late_latched=1 at cycle 100, late_cnt=1 and acq_dv still 1.
- When count drops to 400, expect acq_dv=0 and block_cnt=1.
REQ-038 Release exactly on timer value TIMEOUT_CYC-1.
- Expect IDLE, block_cnt incremented, late_latched=0.
REQ-039 fifo_of pulse, then acq_clr, then fifo_of together with acq_clr.
- Expect of_latched 1 -> 0 -> 1.
- Expect block_cnt unchanged throughout.
REQ-040 Count at 700, then stats_clr with count=300.
- Expect peak_fill=700 before the clear and 300 after; block_cnt=0 and late_cnt=0.
- Then 300 late events: expect late_cnt to saturate at 255.
REQ-041 TICK_DIV=10, with rst asserted mid-PEND.
- Expect sec_tick every 10 cycles and led_alive toggling.
- After rst: all outputs 0 and the heartbeat restarts from 0.
